// File: rtl/attention_pkg.sv
// Shared attention-layer types: Q8.8 element/product types, FSM states
// and the shift-and-saturate helper used by score and output stages.
package attention_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 2*DW + 8;

  typedef logic signed [DW-1:0]    elem_t;
  typedef logic signed [2*DW-1:0]  prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  localparam elem_t E_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam elem_t E_MIN = {1'b1, {(DW-1){1'b0}}};

  // Floor shift back to Q8.8, clamped to the element range.
  function automatic elem_t sat_shift(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC;
    if (sh > acc_t'(E_MAX)) return E_MAX;
    if (sh < acc_t'(E_MIN)) return E_MIN;
    return elem_t'(sh);
  endfunction

endpackage

// File: rtl/attention_mac.sv
// Two-stage MAC: registered product, then accumulate; the result of the
// last term of a dot product is presented with wr for one cycle.
module attention_mac
  import attention_pkg::*;
#(
  parameter int ACCW = 2*DW + 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  last,
  input  elem_t a,
  input  elem_t b,
  output logic  wr,
  output elem_t res
);

  prod_t                  p;
  logic                   v1;
  logic                   l1;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;

  assign sum = acc + ACCW'(p);
  assign wr  = v1 && l1;
  assign res = sat_shift(acc_t'(sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      v1  <= 1'b0;
      l1  <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= en;
      l1 <= en && last;
      if (en) p <= prod_t'(a) * prod_t'(b);
      if (v1) acc <= l1 ? '0 : sum;
    end
  end

endmodule

// File: rtl/attention_sv.sv
// Attention output stage: O = S * V in Q8.8 using one shared MAC,
// with valid/ready handshakes on both sides.
module attention_sv
  import attention_pkg::*;
#(
  parameter int N_TOK = 4,
  parameter int D     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_TOK*N_TOK*DW-1:0] S,
  input  logic [N_TOK*D*DW-1:0]   V,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [N_TOK*D*DW-1:0]   O,
  output logic                    busy
);

  localparam int KW   = (N_TOK > 1) ? $clog2(N_TOK) : 1;
  localparam int JW   = (D > 1) ? $clog2(D) : 1;
  localparam int OW   = (N_TOK*D > 1) ? $clog2(N_TOK*D) : 1;
  localparam int ACCW = 2*DW + $clog2(N_TOK);

  state_t state, nxt;

  logic [N_TOK*N_TOK*DW-1:0] sb;
  logic [N_TOK*D*DW-1:0]     vb;
  logic [N_TOK*D*DW-1:0]     o_q;
  logic [KW-1:0]             i, k;
  logic [JW-1:0]             j;
  logic [OW-1:0]             wi;
  logic                      fin;
  logic                      iss;
  logic                      accept;
  logic                      last_k;
  logic                      mac_wr;
  elem_t                     a, b, mac_res;

  assign O      = o_q;
  assign accept = (state == IDLE) && s_valid && s_ready;
  assign iss    = (state == COMPUTE) && !fin;
  assign last_k = (k == KW'(N_TOK-1));

  always_comb begin
    a = sb[(int'(i)*N_TOK + int'(k))*DW +: DW];
    b = vb[(int'(k)*D + int'(j))*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt     = state;
    s_ready = 1'b0;
    o_valid = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = !reset_n;
        if (s_valid && !reset_n) nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (mac_wr && fin) nxt = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        if (o_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      sb  <= '0;
      vb  <= '0;
      o_q <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      wi  <= '0;
      fin <= 1'b0;
    end else begin
      if (accept) begin
        sb  <= S;
        vb  <= V;
        i   <= '0;
        j   <= '0;
        k   <= '0;
        fin <= 1'b0;
      end
      if (iss) begin
        wi <= OW'(int'(i)*D + int'(j));
        if (!last_k) begin
          k <= k + 1'b1;
        end else begin
          k <= '0;
          if (j != JW'(D-1)) begin
            j <= j + 1'b1;
          end else begin
            j <= '0;
            if (i == KW'(N_TOK-1)) fin <= 1'b1;
            else                   i   <= i + 1'b1;
          end
        end
      end
      // wi still names the element whose last term just left the MAC
      if (mac_wr) o_q[int'(wi)*DW +: DW] <= mac_res;
    end
  end

  attention_mac #(.ACCW(ACCW)) u_mac (
    .clk  (clk),
    .rst  (reset_n),
    .en   (iss),
    .last (last_k),
    .a    (a),
    .b    (b),
    .wr   (mac_wr),
    .res  (mac_res)
  );

endmodule

// File: tb/tb_attention_sv.sv
// Scoreboard bench for attention_sv: directed jobs push expected O,
// a negedge monitor pops and compares on every output handshake.
module tb_attention_sv;

  localparam int W = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  S = '0;
  logic [W-1:0]  V = '0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [W-1:0]  O;
  logic          busy;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int rx    = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  attention_sv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .S       (S),
    .V       (V),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .O       (O),
    .busy    (busy)
  );

  task automatic chk(input string nm, input logic [W+3:0] act,
                     input logic [W+3:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!reset_n && o_valid && o_ready) begin
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_output: got %h expected none", O);
      end else begin
        chk("O", {4'h0, O}, {4'h0, q.pop_front()});
      end
      rx++;
    end
  end

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    logic [W-1:0] r;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ident_s();
    logic [W-1:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) r[(d*4+d)*16 +: 16] = 16'h0100;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp_v(input int scale);
    logic [W-1:0] r;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(scale*(e+1));
    return r;
  endfunction

  task automatic run_job(input logic [W-1:0] s_in, input logic [W-1:0] v_in,
                         input logic [W-1:0] exp, input bit push);
    int n;
    n = 0;
    while (!s_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      ntot++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    S       = s_in;
    V       = v_in;
    s_valid = 1'b1;
    if (push) q.push_back(exp);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (rx < target && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      ntot++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", rx, target);
    end
  endtask

  initial begin
    logic [W-1:0] sv1, vv1, tv;
    int a0, n;

    repeat (3) tick();
    chk("ready_in_reset", {259'b0, s_ready}, '0);
    reset_n = 1'b0;
    #1;
    chk("rst_s_ready", {259'b0, s_ready}, {259'b0, 1'b1});
    chk("rst_o_valid", {259'b0, o_valid}, '0);
    chk("rst_busy", {259'b0, busy}, '0);
    chk("rst_O", {4'h0, O}, '0);

    // identity with latency measurement
    tick();
    run_job(ident_s(), ramp_v(256), ramp_v(256), 1'b1);
    a0 = cyc;
    n = 0;
    while (!o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 260'(cyc - a0), 260'(65));
    wait_out(1);

    run_job(fill(16'h0040), fill(16'h0400), fill(16'h0400), 1'b1);
    wait_out(2);
    run_job(fill(16'h7fff), fill(16'h7fff), fill(16'h7fff), 1'b1);
    wait_out(3);
    run_job(fill(16'h7fff), fill(16'h8000), fill(16'h8000), 1'b1);
    wait_out(4);

    sv1 = '0;
    sv1[15:0] = 16'h0001;
    vv1 = '0;
    vv1[15:0] = 16'hffff;
    tv = '0;
    tv[15:0] = 16'hffff;
    run_job(sv1, vv1, tv, 1'b1);
    wait_out(5);

    // backpressure, with a second job waiting on s_valid
    o_ready = 1'b0;
    run_job(ident_s(), ramp_v(3), ramp_v(3), 1'b1);
    n = 0;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    S       = fill(16'h0040);
    V       = fill(16'h0400);
    s_valid = 1'b1;
    q.push_back(fill(16'h0400));
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {2'b0, o_valid, s_ready, O},
          {2'b0, 1'b1, 1'b0, ramp_v(3)});
      tick();
    end
    o_ready = 1'b1;
    tick();
    chk("bp_release_ready", {259'b0, s_ready}, {259'b0, 1'b1});
    tick();
    chk("b2b_accept", {258'b0, busy, s_ready}, {258'b0, 2'b10});
    s_valid = 1'b0;
    wait_out(7);

    // reset in the middle of a job
    run_job(fill(16'h0100), fill(16'h0200), '0, 1'b0);
    repeat (30) tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_state", {257'b0, o_valid, busy, s_ready},
        {257'b0, 3'b001});
    chk("midrst_O", {4'h0, O}, '0);
    tick();
    run_job(ident_s(), ramp_v(256), ramp_v(256), 1'b1);
    wait_out(8);

    repeat (3) tick();
    chk("queue_empty", 260'(q.size()), '0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/attention_sv.md
Name: attention_sv

Overview:
- Consumer-side stage for the attention score producer; computes attention output O = S·V.
- Accepts one packed score matrix S (N_TOK×N_TOK) and one value matrix V (N_TOK×D), both signed Q8.8.
- Runs a single time-multiplexed MAC, then presents packed O (N_TOK×D) on a valid/ready output.
- Sits directly downstream of the score producer in the attention layer datapath.

Parameters:
- N_TOK, 4, number of tokens (rows of S and V).
- D, 4, value/embedding width per token.
- DW, 16, element width, signed two's complement.
- FRAC, 8, fractional bits of the Q-format.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
- s_valid  in  1  S/V input valid.
- s_ready  out  1  block can accept S/V.
- S  in  N_TOK*N_TOK*DW  score matrix; element [i][k] at bits ((i*N_TOK+k)*DW) +: DW.
- V  in  N_TOK*D*DW  value matrix; element [k][j] at bits ((k*D+j)*DW) +: DW.
- o_valid  out  1  O valid.
- o_ready  in  1  downstream accepts O.
- O  out  N_TOK*D*DW  result; element [i][j] at bits ((i*D+j)*DW) +: DW.
- busy  out  1  high in COMPUTE or DONE.

Behaviour:
- Reset (reset_n=1 at a rising edge): state=IDLE, s_ready=0 during reset, O=0, o_valid=0, busy=0, counters and accumulator cleared. The first cycle after reset deasserts: s_ready=1.
- FSM:
  - IDLE: s_ready=1. On s_valid&&s_ready, S and V are registered into internal buffers, and i/j/k are set to 0. Next state is COMPUTE.
  - COMPUTE: s_ready=0. One MAC per cycle: acc += S[i][k]*V[k][j].
    - Loop order: k innermost, then j, then i.
    - When k==N_TOK-1, the result for (i,j) is written into the O register and acc is cleared.
    - After (i=N_TOK-1, j=D-1, k=N_TOK-1), the next state is DONE.
  - DONE: o_valid=1. O is held stable. On o_valid&&o_ready, o_valid drops next cycle and the next state is IDLE.
- Latency: handshake accepted at edge T. COMPUTE spans N_TOK*N_TOK*D cycles (64 at defaults). o_valid is high from edge T+65 at defaults.
- Throughput: one job per (N_TOK*N_TOK*D + 2) cycles minimum, with o_ready tied high.
- Arithmetic:
  - Product is 2*DW signed.
  - Accumulator is 2*DW+$clog2(N_TOK) signed.
  - Result = acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - Result saturates to [−2^(DW−1), 2^(DW−1)−1], i.e. 0x8000..0x7FFF.
- Input buffering: S and V are captured only on the accept edge. Input changes during COMPUTE/DONE have no effect. s_valid while s_ready=0 is ignored (no queueing).
- O register: holds its last value until overwritten by the next job's writes. Downstream samples O only while o_valid=1.
- Backpressure: in DONE with o_ready=0 indefinitely, O and o_valid stay constant and s_ready stays 0.
- Reset mid-operation: any state returns to IDLE on the next edge. The partial result is discarded and O is cleared to 0.

Decomposition:
- attention_pkg (shared with the score producer):
  - DW and FRAC constants.
  - typedef elem_t (logic signed [DW-1:0]).
  - typedef prod_t (logic signed [2*DW-1:0]).
  - function sat_shift(acc), returning elem_t: arithmetic shift by FRAC plus saturation.
  - enum state_t {IDLE, COMPUTE, DONE}.
- One sub-module: attention_mac.
  - Registered multiply-accumulate with clear and sat_shift output.
  - Instantiated once by attention_sv, which owns the FSM, counters, buffers and O register.

Test Plan:
- Identity: S diagonal 0x0100 (1.0), off-diagonal 0; V[k][j]=0x0100*(k*4+j+1) -> O==V exactly; o_valid rises 65 cycles after accept.
- Averaging: all S=0x0040 (0.25); V column j=0x0400 (4.0) for all k -> every O element 0x0400.
- Saturation: all S=0x7FFF, all V=0x7FFF -> O all 0x7FFF. With V all 0x8000 and S all 0x7FFF -> O all 0x8000.
- Truncation sign: S[0][0]=0x0001, V[0][0]=0xFFFF, rest 0 -> O[0][0]=0xFFFF (−1 LSB, floor); all other elements 0.
- Backpressure/back-to-back: hold o_ready=0 for 10 cycles in DONE -> O, o_valid stable and s_ready=0 throughout. On release, s_ready rises the next cycle; a second job queued on s_valid is accepted immediately and its result is correct.
- Reset mid-compute: assert reset_n=1 for 1 cycle at COMPUTE cycle 30 -> next cycle state IDLE, O=0, o_valid=0, busy=0. A subsequent identity job produces correct O.
